alu_exec_unit: RTL

- Execute-stage datapath that consumes the 4-bit ALU control code and performs the operation on two WIDTH-bit operands.
- Sits directly downstream of the ALU control decoder. Driven by the EX stage, which issues operands with a start pulse.
- Logical/arithmetic ops complete in 1 cycle. Shifts run iteratively, 1 bit per cycle, to keep area small.
- Produces a registered result plus carry/zero/negative flags, which feed writeback and the branch unit.

---
 rtl/alu_exec_if.sv | 33 +++
 rtl/alu_exec_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// alu_exec_if
//   Bundles the operation handshake between the EX stage (master) and the
//   ALU execute unit (slave).
//   master -> slave : start, alu_ctrl, a, b, shamt
//   slave -> master : busy, done, result, carry, zero, negative
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) ();

  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;

  modport master (
    output start, alu_ctrl, a, b, shamt,
    input  busy, done, result, carry, zero, negative
  );

  modport slave (
    input  start, alu_ctrl, a, b, shamt,
    output busy, done, result, carry, zero, negative
  );

endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU. Logical/arithmetic codes finish one cycle after the
//   start edge; shifts step one bit per cycle and finish n+1 cycles after
//   the start edge. Result and flags are registered and held until the
//   next completed operation.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts any operation, no done)
//   bus  - alu_exec_if.slave: start/alu_ctrl/a/b/shamt in,
//          busy/done/result/carry/zero/negative out
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic     clk,
  input  logic     rst,
  alu_exec_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       shop_reg, shop_next;     // 00 SLL, 01 SRL, 10 SRA
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             carry_reg, carry_next;
  logic             zero_reg, zero_next;
  logic             neg_reg, neg_next;

  // ---------------------------------------------------------------------
  // Single-cycle operation results, computed straight from the inputs at
  // the start edge so they can be registered on entry to FIN.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] diff_x;
  logic [WIDTH-1:0] below_any;   // below_any[i]: some bit of diff_x under i is set
  logic [WIDTH-1:0] lsb_onehot;  // isolates the lowest set bit of diff_x
  logic [SHW-1:0]   diff_idx;

  assign add_sum = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_x  = bus.a ^ bus.b;

  assign below_any[0]  = 1'b0;
  assign lsb_onehot[0] = diff_x[0];

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_lsb
      assign below_any[gi]  = below_any[gi-1] | diff_x[gi-1];
      assign lsb_onehot[gi] = diff_x[gi] & ~below_any[gi];
    end
  endgenerate

  // At most one bit of lsb_onehot is set, so OR-ing indices encodes it.
  // When a==b nothing is set and the index stays 0.
  always_comb begin
    diff_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lsb_onehot[i]) begin
        diff_idx = diff_idx | SHW'(i);
      end
    end
  end

  logic             is_shift;
  logic [SHW-1:0]   shift_n;
  logic [WIDTH-1:0] op_result;
  logic             op_carry;

  // Shift codes are x100/x101/x110; bit 3 selects the variable amount.
  assign is_shift = bus.alu_ctrl[2] & (bus.alu_ctrl[1:0] != 2'b11);
  assign shift_n  = bus.alu_ctrl[3] ? bus.b[SHW-1:0] : bus.shamt;

  always_comb begin
    op_result = '0;
    op_carry  = 1'b0;
    case (bus.alu_ctrl)
      4'b1000: begin
        op_result = add_sum[WIDTH-1:0];
        op_carry  = add_sum[WIDTH];
      end
      4'b1001: op_result = ~bus.b + 1'b1;
      4'b1010: op_result = bus.a & bus.b;
      4'b1011: op_result = bus.a ^ bus.b;
      4'b1111: op_result = WIDTH'(diff_idx);
      default: begin
        op_result = '0;
        op_carry  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // One-bit shift step; shift_out is the bit leaving the register.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] shift_step;
  logic             shift_out;

  always_comb begin
    shift_step = shreg_reg;
    shift_out  = 1'b0;
    case (shop_reg)
      2'b00: begin
        shift_step = {shreg_reg[WIDTH-2:0], 1'b0};
        shift_out  = shreg_reg[WIDTH-1];
      end
      2'b01: begin
        shift_step = {1'b0, shreg_reg[WIDTH-1:1]};
        shift_out  = shreg_reg[0];
      end
      default: begin
        shift_step = {shreg_reg[WIDTH-1], shreg_reg[WIDTH-1:1]};
        shift_out  = shreg_reg[0];
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------
  logic             fin_load;
  logic [WIDTH-1:0] fin_result;
  logic             fin_carry;

  always_comb begin
    state_next = state_reg;
    shop_next  = shop_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    fin_load   = 1'b0;
    fin_result = '0;
    fin_carry  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (is_shift && (shift_n != '0)) begin
            shreg_next = bus.a;
            cnt_next   = shift_n;
            shop_next  = bus.alu_ctrl[1:0];
            state_next = SHIFT;
          end else if (is_shift) begin
            // Zero-length shift passes a through with no carry.
            fin_load   = 1'b1;
            fin_result = bus.a;
            state_next = FIN;
          end else begin
            fin_load   = 1'b1;
            fin_result = op_result;
            fin_carry  = op_carry;
            state_next = FIN;
          end
        end
      end

      SHIFT: begin
        shreg_next = shift_step;
        cnt_next   = cnt_reg - 1'b1;
        // The last step goes straight into the result registers so the
        // shift finishes n+1 cycles after the start edge.
        if (cnt_reg == SHW'(1)) begin
          fin_load   = 1'b1;
          fin_result = shift_step;
          fin_carry  = shift_out;
          state_next = FIN;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    result_next = fin_load ? fin_result : result_reg;
    carry_next  = fin_load ? fin_carry : carry_reg;
    zero_next   = fin_load ? (fin_result == '0) : zero_reg;
    neg_next    = fin_load ? fin_result[WIDTH-1] : neg_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shop_reg   <= 2'b00;
      shreg_reg  <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shop_reg   <= shop_next;
      shreg_reg  <= shreg_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      carry_reg  <= carry_next;
      zero_reg   <= zero_next;
      neg_reg    <= neg_next;
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == FIN);
  assign bus.result   = result_reg;
  assign bus.carry    = carry_reg;
  assign bus.zero     = zero_reg;
  assign bus.negative = neg_reg;

endmodule
